rvfifo_cc_param: RTL and testbench

//  Parametrised single-clock ready/valid FIFO: sc_rvd_in stream in, sc_rvd_out stream out.

---
 rtl/rvfifo_pkg.sv | 29 ++
 rtl/rvfifo_cc_param_slice.sv | 56 +++++
 rtl/rvfifo_cc_param.sv | 165 ++++++++++++++++
 tb/tb_rvfifo_cc_param.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvfifo_pkg.sv
// ---------------------------------------------------------------------------
// rvfifo_pkg
//   Shared types and helper functions for the parametrised ready/valid FIFO.
//   - rv_flags_t : registered almost_full / almost_empty flag pair
//   - ptr_inc    : pointer increment with explicit wrap at depth-1
//   - lvl_w      : width of the occupancy output for a given depth/slice option
// ---------------------------------------------------------------------------
package rvfifo_pkg;

  typedef struct packed {
    logic almost_full;
    logic almost_empty;
  } rv_flags_t;

  // The wrap uses an explicit compare so that depths which are not a power
  // of two still cycle through exactly DEPTH slots.
  function automatic int unsigned ptr_inc(input int unsigned ptr,
                                          input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

  // Occupancy counts the array plus the optional output slice, and must be
  // able to represent the full value (hence the +1).
  function automatic int unsigned lvl_w(input int unsigned depth,
                                        input int unsigned oreg);
    return $clog2(depth + oreg + 1);
  endfunction

endpackage

// File: rtl/rvfifo_cc_param_slice.sv
// ---------------------------------------------------------------------------
// rv_reg_slice
//   One-entry ready/valid register stage. Accepts a new word whenever it is
//   empty or its current word is being taken in the same cycle, so it
//   sustains one transfer per cycle under continuous m_ready.
// Ports
//   clk, reset       clock (rising edge), asynchronous active-high reset
//   flush            synchronous clear of the held word
//   s_data/s_valid/s_ready   upstream stream
//   m_data/m_valid/m_ready   downstream stream
// ---------------------------------------------------------------------------
module rv_reg_slice #(
  parameter int unsigned T = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic [T-1:0] s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [T-1:0] m_data,
  output logic         m_valid,
  input  logic         m_ready
);

  logic         valid_q, valid_d;
  logic [T-1:0] data_q,  data_d;

  assign s_ready = !valid_q | m_ready;
  assign m_valid = valid_q;
  assign m_data  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (s_valid && s_ready) begin
      valid_d = 1'b1;
      data_d  = s_data;
    end else if (m_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/rvfifo_cc_param.sv
// ---------------------------------------------------------------------------
// rvfifo_cc_param
//   Single-clock ready/valid FIFO with configurable depth, optional output
//   register slice, registered fill level, almost-full/almost-empty flags and
//   a synchronous flush.
// Ports
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   flush               synchronous discard of all contents
//   s_port_*            input stream (s_port_ready is registered: !array full)
//   m_port_*            output stream
//   level               occupancy including the output slice
//   almost_full         level >= AF_LEV   (registered)
//   almost_empty        level <= AE_LEV   (registered)
// ---------------------------------------------------------------------------
module rvfifo_cc_param
  import rvfifo_pkg::*;
#(
  parameter int unsigned T      = 64,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned OREG   = 0,
  parameter int unsigned AF_LEV = 12,
  parameter int unsigned AE_LEV = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              flush,
  input  logic [T-1:0]                      s_port_data,
  input  logic                              s_port_valid,
  output logic                              s_port_ready,
  output logic [T-1:0]                      m_port_data,
  output logic                              m_port_valid,
  input  logic                              m_port_ready,
  output logic [lvl_w(DEPTH, OREG)-1:0]     level,
  output logic                              almost_full,
  output logic                              almost_empty
);

  localparam int unsigned LW = lvl_w(DEPTH, OREG);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  if (DEPTH < 2) begin : g_chk_depth
    $error("rvfifo_cc_param: DEPTH must be at least 2");
  end
  if (AF_LEV > DEPTH + OREG) begin : g_chk_af
    $error("rvfifo_cc_param: AF_LEV exceeds total capacity");
  end
  if (AE_LEV >= AF_LEV) begin : g_chk_ae
    $error("rvfifo_cc_param: AE_LEV must be below AF_LEV");
  end

  logic [T-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          ready_q,  ready_d;
  logic [LW-1:0] level_q,  level_d;
  rv_flags_t     flags_q,  flags_d;

  logic          push;
  logic          arr_valid;
  logic          arr_ready;
  logic          arr_pop;
  logic          out_pop;
  logic [T-1:0]  arr_data;

  assign s_port_ready = ready_q;
  assign push         = s_port_valid & ready_q;
  assign arr_valid    = (count_q != '0);
  assign arr_data     = mem_q[rd_ptr_q];
  assign arr_pop      = arr_valid & arr_ready;
  assign out_pop      = m_port_valid & m_port_ready;

  assign level        = level_q;
  assign almost_full  = flags_q.almost_full;
  assign almost_empty = flags_q.almost_empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ready_d  = ready_q;
    level_d  = level_q;
    flags_d  = flags_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ready_d  = 1'b1;
      level_d  = '0;
      flags_d  = '{almost_full: 1'b0, almost_empty: 1'b1};
    end else begin
      if (push)    wr_ptr_d = PW'(ptr_inc(32'(wr_ptr_q), DEPTH));
      if (arr_pop) rd_ptr_d = PW'(ptr_inc(32'(rd_ptr_q), DEPTH));

      case ({push, arr_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase

      // Level tracks the external handshakes, so it naturally includes a
      // word parked in the output slice.
      case ({push, out_pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase

      // Ready and flags are computed from next-state so they can be
      // registered without lagging a cycle behind the contents.
      ready_d              = (count_d != CW'(DEPTH));
      flags_d.almost_full  = (level_d >= LW'(AF_LEV));
      flags_d.almost_empty = (level_d <= LW'(AE_LEV));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
      level_q  <= '0;
      flags_q  <= '{almost_full: 1'b0, almost_empty: 1'b1};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
      level_q  <= level_d;
      flags_q  <= flags_d;
    end
  end

  // NOTE: the storage array has no reset; stale entries are never visible
  // because validity comes from count_q, and leaving it unreset lets it map
  // onto RAM.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= s_port_data;
  end

  if (OREG != 0) begin : g_oreg
    rv_reg_slice #(.T(T)) u_slice (
      .clk     (clk),
      .reset   (reset),
      .flush   (flush),
      .s_data  (arr_data),
      .s_valid (arr_valid),
      .s_ready (arr_ready),
      .m_data  (m_port_data),
      .m_valid (m_port_valid),
      .m_ready (m_port_ready)
    );
  end else begin : g_fwft
    assign arr_ready    = m_port_ready;
    assign m_port_valid = arr_valid;
    // Data is forced to zero when nothing is valid so that the unreset
    // array contents never reach the port.
    assign m_port_data  = arr_valid ? arr_data : '0;
  end

endmodule

// File: tb/tb_rvfifo_cc_param.sv
// ---------------------------------------------------------------------------
// tb_rvfifo_cc_param
//   Directed bench for rvfifo_cc_param. Instance u_a uses the fall-through
//   configuration (OREG=0), instance u_b adds the output slice (OREG=1).
//   Both use T=8, DEPTH=4, AF_LEV=3, AE_LEV=1 and share clock and reset.
// ---------------------------------------------------------------------------
module tb_rvfifo_cc_param;

  logic       clk = 1'b0;
  logic       reset;

  logic       a_flush, a_s_valid, a_s_ready, a_m_valid, a_m_ready, a_af, a_ae;
  logic [7:0] a_s_data, a_m_data;
  logic [2:0] a_level;

  logic       b_flush, b_s_valid, b_s_ready, b_m_valid, b_m_ready, b_af, b_ae;
  logic [7:0] b_s_data, b_m_data;
  logic [2:0] b_level;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q [$];
  logic [7:0] sb    [$];
  logic [7:0] exp_b;
  logic [7:0] nxt;

  always #5 clk = ~clk;

  rvfifo_cc_param #(.T(8), .DEPTH(4), .OREG(0), .AF_LEV(3), .AE_LEV(1)) u_a (
    .clk          (clk),
    .reset        (reset),
    .flush        (a_flush),
    .s_port_data  (a_s_data),
    .s_port_valid (a_s_valid),
    .s_port_ready (a_s_ready),
    .m_port_data  (a_m_data),
    .m_port_valid (a_m_valid),
    .m_port_ready (a_m_ready),
    .level        (a_level),
    .almost_full  (a_af),
    .almost_empty (a_ae)
  );

  rvfifo_cc_param #(.T(8), .DEPTH(4), .OREG(1), .AF_LEV(3), .AE_LEV(1)) u_b (
    .clk          (clk),
    .reset        (reset),
    .flush        (b_flush),
    .s_port_data  (b_s_data),
    .s_port_valid (b_s_valid),
    .s_port_ready (b_s_ready),
    .m_port_data  (b_m_data),
    .m_port_valid (b_m_valid),
    .m_port_ready (b_m_ready),
    .level        (b_level),
    .almost_full  (b_af),
    .almost_empty (b_ae)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs driven here are
  // sampled on the following edge and outputs read here are settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    a_flush   = 1'b0; a_s_valid = 1'b0; a_s_data = '0; a_m_ready = 1'b0;
    b_flush   = 1'b0; b_s_valid = 1'b0; b_s_data = '0; b_m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    chk("rst_m_valid", a_m_valid, 0);
    chk("rst_m_data",  a_m_data,  0);
    chk("rst_level",   a_level,   0);
    chk("rst_af",      a_af,      0);
    chk("rst_ae",      a_ae,      1);
    chk("rst_s_ready", a_s_ready, 1);

    // Test 1: reset asserted mid-burst with s_port_valid held high
    a_s_valid = 1'b1; a_s_data = 8'hAA;
    tick();
    chk("t1_pre_valid", a_m_valid, 1);
    chk("t1_pre_data",  a_m_data,  8'hAA);
    a_s_data = 8'hBB;
    #3 reset = 1'b1;
    #1;
    chk("t1_async_m_valid", a_m_valid, 0);
    chk("t1_async_level",   a_level,   0);
    chk("t1_async_ae",      a_ae,      1);
    a_s_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    chk("t1_rel_s_ready", a_s_ready, 1);
    chk("t1_rel_m_valid", a_m_valid, 0);
    chk("t1_rel_level",   a_level,   0);

    // Test 2: fill to full with the consumer stalled
    a_m_ready = 1'b0;
    a_s_valid = 1'b1;
    a_s_data  = 8'h11; tick();
    chk("t2_l1_level", a_level, 1);
    chk("t2_l1_ae",    a_ae,    1);
    chk("t2_l1_af",    a_af,    0);
    a_s_data  = 8'h22; tick();
    chk("t2_l2_ae",    a_ae,    0);
    chk("t2_l2_af",    a_af,    0);
    a_s_data  = 8'h33; tick();
    chk("t2_l3_level", a_level, 3);
    chk("t2_l3_af",    a_af,    1);
    chk("t2_l3_ready", a_s_ready, 1);
    a_s_data  = 8'h44; tick();
    chk("t2_l4_level", a_level, 4);
    chk("t2_l4_ready", a_s_ready, 0);
    a_s_data  = 8'h55; tick();
    chk("t2_blocked_level", a_level, 4);
    chk("t2_blocked_ready", a_s_ready, 0);
    chk("t2_head_data",     a_m_data, 8'h11);
    a_s_valid = 1'b0;

    // Test 3: drain, one word per cycle
    a_m_ready = 1'b1;
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      chk("t3_valid", a_m_valid, 1);
      chk("t3_data",  a_m_data,  exp_q[i]);
      chk("t3_level", a_level,   4 - i);
      tick();
      if (i == 0) chk("t3_ready_after_pop", a_s_ready, 1);
    end
    chk("t3_end_valid", a_m_valid, 0);
    chk("t3_end_level", a_level,   0);
    chk("t3_end_ae",    a_ae,      1);

    // Test 4: level 2, then push and pop every cycle across pointer wraps
    a_m_ready = 1'b0;
    a_s_valid = 1'b1;
    a_s_data  = 8'hE0; tick();
    a_s_data  = 8'hE1; tick();
    exp_q = '{8'hE0, 8'hE1};
    a_m_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("t4_level", a_level,   2);
      chk("t4_valid", a_m_valid, 1);
      chk("t4_data",  a_m_data,  exp_q[0]);
      a_s_data = 8'(i);
      tick();
      void'(exp_q.pop_front());
      exp_q.push_back(8'(i));
    end
    chk("t4_end_level", a_level,  2);
    chk("t4_end_data",  a_m_data, 8'h08);
    a_s_valid = 1'b0;
    a_m_ready = 1'b0;

    // Test 5: flush at level 3 with a push and a pop pending
    a_s_valid = 1'b1; a_s_data = 8'hC3; tick();
    chk("t5_pre_level", a_level, 3);
    a_flush = 1'b1; a_s_data = 8'hF5; a_m_ready = 1'b1;
    tick();
    a_flush = 1'b0; a_s_valid = 1'b0; a_m_ready = 1'b0;
    chk("t5_level",   a_level,   0);
    chk("t5_m_valid", a_m_valid, 0);
    chk("t5_ae",      a_ae,      1);
    chk("t5_af",      a_af,      0);
    chk("t5_s_ready", a_s_ready, 1);
    a_s_valid = 1'b1; a_s_data = 8'h5A; tick();
    a_s_valid = 1'b0;
    chk("t5_after_data",  a_m_data, 8'h5A);
    chk("t5_after_level", a_level,  1);
    a_m_ready = 1'b1; tick();
    a_m_ready = 1'b0;
    chk("t5_after_empty", a_m_valid, 0);

    // Test 6: output slice, two-cycle latency
    b_s_valid = 1'b1; b_s_data = 8'hA5; tick();
    b_s_valid = 1'b0;
    chk("t6_lat1_valid", b_m_valid, 0);
    chk("t6_lat1_level", b_level,   1);
    tick();
    chk("t6_lat2_valid", b_m_valid, 1);
    chk("t6_lat2_data",  b_m_data,  8'hA5);
    chk("t6_lat2_level", b_level,   1);
    b_m_ready = 1'b1; tick();
    b_m_ready = 1'b0;
    chk("t6_pop_valid", b_m_valid, 0);
    chk("t6_pop_level", b_level,   0);

    // Capacity of array plus slice is five words
    b_s_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      b_s_data = 8'hB0 + 8'(i);
      tick();
    end
    chk("t6_cap_level", b_level,   5);
    chk("t6_cap_ready", b_s_ready, 0);
    chk("t6_cap_af",    b_af,      1);
    b_s_data = 8'hB6; tick();
    b_s_valid = 1'b0;
    chk("t6_cap_blocked", b_level, 5);
    b_m_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      chk("t6_drain_valid", b_m_valid, 1);
      chk("t6_drain_data",  b_m_data,  8'hB0 + 8'(i));
      chk("t6_drain_level", b_level,   6 - i);
      tick();
    end
    chk("t6_drain_end", b_m_valid, 0);

    // Random backpressure against an in-order scoreboard
    nxt = 8'h00;
    for (int i = 0; i < 300; i++) begin
      b_s_valid = 1'($urandom_range(0, 1));
      b_s_data  = nxt;
      b_m_ready = ($urandom_range(0, 3) != 0);
      #1;
      chk("rand_level", b_level, sb.size());
      if (b_m_valid && b_m_ready) begin
        if (sb.size() == 0) begin
          chk("rand_spurious_valid", b_m_valid, 0);
        end else begin
          exp_b = sb.pop_front();
          chk("rand_data", b_m_data, exp_b);
        end
      end
      if (b_s_valid && b_s_ready) begin
        sb.push_back(nxt);
        nxt = nxt + 8'h01;
      end
      tick();
    end
    b_s_valid = 1'b0;
    b_m_ready = 1'b1;
    for (int k = 0; k < 20 && sb.size() != 0; k++) begin
      if (b_m_valid) begin
        exp_b = sb.pop_front();
        chk("drain_data", b_m_data, exp_b);
      end
      tick();
    end
    chk("drain_level", b_level,   0);
    chk("drain_valid", b_m_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
